// File: rtl/adc_serial_multi_pkg.sv
// Shared types and elaboration helpers for the multi-channel serial ADC reader.
// Optional feature macro used by this design: ADC_AVG_EN (per-channel frame averaging).
package adc_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        CONV
    } adc_state_e;

    // Total clk cycles from SETUP entry to the next SETUP entry while running.
    function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                 input int unsigned clk_div,
                                                 input int unsigned conv_cycles);
        return clk_div * (1 + 2 * data_w) + conv_cycles;
    endfunction

    // Width of a counter that runs 0..n-1 (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int unsigned ch_num,
                                     input int unsigned data_w,
                                     input int unsigned clk_div,
                                     input int unsigned conv_cycles,
                                     input int unsigned avg_log2);
        return (ch_num >= 1) && (ch_num <= 8) &&
               (data_w >= 4) && (data_w <= 16) &&
               (clk_div >= 1) && (conv_cycles >= 1) &&
               (avg_log2 >= 1) && (avg_log2 <= 4);
    endfunction

endpackage

// File: rtl/adc_serial_multi_if.sv
// ADC pins plus the result valid/ready handshake, bundled for the reader top.
// The master modport is the reader; the slave modport is the ADC/consumer side.
interface adc_serial_multi_if #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned DATA_W = 8
) ();
    logic                       en;
    logic [CH_NUM-1:0]          AD_DO;
    logic                       AD_CS;
    logic                       AD_CLK;
    logic [CH_NUM*DATA_W-1:0]   data_out;
    logic                       data_valid;
    logic                       data_ready;
    logic                       overrun;

    modport master (
        input  en, AD_DO, data_ready,
        output AD_CS, AD_CLK, data_out, data_valid, overrun
    );

    modport slave (
        output en, AD_DO, data_ready,
        input  AD_CS, AD_CLK, data_out, data_valid, overrun
    );
endinterface

// File: rtl/adc_serial_multi_shift_ch.sv
// One channel of the serial ADC reader: MSB-first shift register and, when
// ADC_AVG_EN is defined, a frame accumulator that yields a truncated mean.
module adc_shift_ch #(
    parameter int unsigned DATA_W = 8
`ifdef ADC_AVG_EN
    ,
    parameter int unsigned AVG_LOG2 = 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sd,         // serial data from this channel's ADC
    input  logic              shift_en,   // AD_CLK rising this cycle
    input  logic              pub,        // frame complete this cycle
    input  logic              clr,        // run stopping; drop any partial state
    output logic [DATA_W-1:0] result,
    output logic              res_valid   // result is to be published this cycle
);

    logic [DATA_W-1:0] sh_q;

    // Capture one bit per AD_CLK rise; start each frame from a clean register.
    always_ff @(posedge clk) begin
        if (rst || pub || clr) begin
            sh_q <= '0;
        end else if (shift_en) begin
            sh_q <= {sh_q[DATA_W-2:0], sd};
        end
    end

`ifdef ADC_AVG_EN
    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    sum;
    logic [AVG_LOG2-1:0] grp_q;
    logic                grp_last;

    // Running sum including the frame that is completing now.
    always_comb begin
        sum       = acc_q + {{AVG_LOG2{1'b0}}, sh_q};
        grp_last  = &grp_q;
        result    = sum[ACC_W-1:AVG_LOG2];
        res_valid = pub && grp_last;
    end

    // Accumulate frames; restart the group after it publishes or the run stops.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= '0;
            grp_q <= '0;
        end else if (pub) begin
            if (grp_last) begin
                acc_q <= '0;
                grp_q <= '0;
            end else begin
                acc_q <= sum;
                grp_q <= grp_q + 1'b1;
            end
        end
    end
`else
    // Every completed frame publishes its raw sample.
    always_comb begin
        result    = sh_q;
        res_valid = pub;
    end
`endif

endmodule

// File: rtl/adc_serial_multi.sv
// Multi-channel serial ADC reader: one shared AD_CS/AD_CLK pair, CH_NUM data
// lines captured in parallel, results offered on a valid/ready handshake.
// Optional feature: define ADC_AVG_EN to publish the mean of 2**AVG_LOG2 frames.
module adc_serial_multi
    import adc_serial_pkg::*;
#(
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CLK_DIV     = 1,
    parameter int unsigned CONV_CYCLES = 22,
    parameter int unsigned AVG_LOG2    = 2
) (
    input logic              clk,
    input logic              rst,
    adc_serial_multi_if.master bus
);

    localparam int unsigned CNT_MAX = (CLK_DIV > CONV_CYCLES) ? CLK_DIV : CONV_CYCLES;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
    localparam int unsigned BIT_W   = cnt_width(DATA_W);

    if (!params_ok(CH_NUM, DATA_W, CLK_DIV, CONV_CYCLES, AVG_LOG2)) begin : g_param_err
        $error("adc_serial_multi: parameter out of range");
    end

    adc_state_e                state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [BIT_W-1:0]          bit_q;
    logic                      cs_q;
    logic                      sclk_q;
    logic [CH_NUM*DATA_W-1:0]  data_q;
    logic                      valid_q;
    logic                      ovr_q;

    logic                      div_end;
    logic                      conv_end;
    logic                      bit_end;
    logic                      shift_en;
    logic                      frame_done;
    logic                      to_idle;
    logic                      publish;
    logic [DATA_W-1:0]         ch_result [CH_NUM];
    logic [CH_NUM-1:0]         ch_rvalid;

    // Phase-end decodes and the per-frame strobes shared by all channels.
    always_comb begin
        div_end    = (cnt_q == CNT_W'(CLK_DIV - 1));
        conv_end   = (cnt_q == CNT_W'(CONV_CYCLES - 1));
        bit_end    = (bit_q == BIT_W'(DATA_W - 1));
        shift_en   = (state_q == SHIFT) && div_end && !sclk_q;
        frame_done = (state_q == SHIFT) && div_end && sclk_q && bit_end;
        to_idle    = (state_q == CONV) && conv_end && !bus.en;
        publish    = &ch_rvalid;
    end

    // Frame sequencer; AD_CS and AD_CLK are updated on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (bus.en) begin
                        state_q <= SETUP;
                        cs_q    <= 1'b0;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        sclk_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else if (bit_end) begin
                            state_q <= CONV;
                            cs_q    <= 1'b1;
                            sclk_q  <= 1'b0;
                        end else begin
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + 1'b1;
                        end
                    end
                end
                CONV: begin
                    if (!conv_end) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        if (bus.en) begin
                            state_q <= SETUP;
                            cs_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        adc_shift_ch #(
            .DATA_W   (DATA_W)
`ifdef ADC_AVG_EN
            ,
            .AVG_LOG2 (AVG_LOG2)
`endif
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .sd        (bus.AD_DO[c]),
            .shift_en  (shift_en),
            .pub       (frame_done),
            .clr       (to_idle),
            .result    (ch_result[c]),
            .res_valid (ch_rvalid[c])
        );
    end

    // Output holding register: a publish always wins over a same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= publish && valid_q && !bus.data_ready;
            if (publish) begin
                for (int c = 0; c < CH_NUM; c++) begin
                    data_q[c*DATA_W +: DATA_W] <= ch_result[c];
                end
                valid_q <= 1'b1;
            end else if (valid_q && bus.data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.AD_CS      = cs_q;
    assign bus.AD_CLK     = sclk_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.overrun    = ovr_q;

endmodule
